// File: rtl/room_icon_drawer.sv
// room_icon_drawer: walks an ICON_W x ICON_H footprint in raster order and
// emits one VGA-adapter pixel write per cycle. A draw pass paints a bordered
// icon; a clear pass paints the footprint in BG_COLOUR.
// Optional feature macro: ICON_CLIP_EN (suppress plot for off-screen pixels).
module room_icon_drawer #(
  parameter int          ICON_W        = 8,
  parameter int          ICON_H        = 8,
  parameter logic [2:0]  LOCK_COLOUR   = 3'b010,
  parameter logic [2:0]  UNLOCK_COLOUR = 3'b100,
  parameter logic [2:0]  BORDER_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] xorigin,
  input  logic [6:0] yorigin,
  input  logic       icon_sel,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t     state_q;
  logic [4:0] col_q, row_q;
  logic [7:0] x0_q;
  logic [6:0] y0_q;
  logic       sel_q, clr_q;

  logic       accept;
  logic       last_col, last_row;
  logic [4:0] col_d, row_d;
  logic [7:0] px_x0;
  logic [6:0] px_y0;
  logic       px_sel, px_clr;
  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] colour_d;
  logic       in_view;
`ifdef ICON_CLIP_EN
  logic [8:0] x_wide;
  logic [7:0] y_wide;
`endif

  // Next pixel to present: origin/selection come straight from the inputs on
  // the accepting edge so the first pixel appears one cycle after acceptance.
  always_comb begin
    accept   = (state_q == S_IDLE) && (start || clear);
    last_col = (col_q == 5'(ICON_W - 1));
    last_row = (row_q == 5'(ICON_H - 1));
    px_x0    = accept ? xorigin  : x0_q;
    px_y0    = accept ? yorigin  : y0_q;
    px_sel   = accept ? icon_sel : sel_q;
    px_clr   = accept ? clear    : clr_q;
    if (accept) begin
      col_d = '0;
      row_d = '0;
    end else if (last_col) begin
      col_d = '0;
      row_d = row_q + 5'd1;
    end else begin
      col_d = col_q + 5'd1;
      row_d = row_q;
    end
    x_d = px_x0 + {3'b000, col_d};
    y_d = px_y0 + {2'b00, row_d};
    if (px_clr)
      colour_d = BG_COLOUR;
    else if (col_d == '0 || col_d == 5'(ICON_W - 1) ||
             row_d == '0 || row_d == 5'(ICON_H - 1))
      colour_d = BORDER_COLOUR;
    else if (px_sel)
      colour_d = LOCK_COLOUR;
    else
      colour_d = UNLOCK_COLOUR;
`ifdef ICON_CLIP_EN
    x_wide  = {1'b0, px_x0} + {4'b0000, col_d};
    y_wide  = {1'b0, px_y0} + {3'b000, row_d};
    in_view = (x_wide <= 9'd159) && (y_wide <= 8'd119);
`else
    in_view = 1'b1;
`endif
  end

  // Pass sequencer with registered VGA outputs; coordinates and colour only
  // update on plotted pixels so they hold while plot is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      sel_q      <= 1'b0;
      clr_q      <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          plot <= 1'b0;
          busy <= 1'b0;
          if (accept) begin
            x0_q    <= xorigin;
            y0_q    <= yorigin;
            sel_q   <= icon_sel;
            clr_q   <= clear;
            col_q   <= col_d;
            row_q   <= row_d;
            plot    <= in_view;
            busy    <= 1'b1;
            state_q <= S_DRAW;
            if (in_view) begin
              vga_x      <= x_d;
              vga_y      <= y_d;
              vga_colour <= colour_d;
            end
          end
        end
        S_DRAW: begin
          if (last_col && last_row) begin
            plot    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            col_q <= col_d;
            row_q <= row_d;
            plot  <= in_view;
            if (in_view) begin
              vga_x      <= x_d;
              vga_y      <= y_d;
              vga_colour <= colour_d;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_room_icon_drawer.sv
// Scoreboard bench for room_icon_drawer: each pass pushes its expected pixel
// stream; an independent monitor pops and compares on every plot strobe.
module tb_room_icon_drawer;

  localparam int W = 8;
  localparam int H = 8;

  logic       clock = 1'b0;
  logic       reset, start, clear, icon_sel;
  logic [7:0] xorigin;
  logic [6:0] yorigin;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb[$];
  int   tests = 0;
  int   fails = 0;

  room_icon_drawer #(.ICON_W(W), .ICON_H(H)) dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear),
    .xorigin(xorigin), .yorigin(yorigin), .icon_sel(icon_sel),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_colour(input int col, input int row,
                                            input logic sel, input logic clr);
    if (clr) return 3'b000;
    if (col == 0 || row == 0 || col == W - 1 || row == H - 1) return 3'b111;
    return sel ? 3'b010 : 3'b100;
  endfunction

  // Push the first npix pixels of a pass in raster order.
  task automatic push_pass(input int x0, input int y0, input logic sel,
                           input logic clr, input int npix);
    pix_t p;
    int   n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          p.x = 8'((x0 + c) % 256);
          p.y = 7'((y0 + r) % 128);
          p.c = exp_colour(c, r, sel, clr);
`ifdef ICON_CLIP_EN
          if ((x0 + c) <= 159 && (y0 + r) <= 119) sb.push_back(p);
`else
          sb.push_back(p);
`endif
        end
        n++;
      end
    end
  endtask

  // Monitor: every plot strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    if (plot) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected none",
                 vga_x, vga_y, vga_colour);
      end else begin
        pix_t e;
        e = sb.pop_front();
        if (vga_x != e.x || vga_y != e.y || vga_colour != e.c) begin
          fails++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  // One pass. poke: pulse start at cycle 10. chg: scramble inputs each cycle.
  // rst_at: assert reset during that cycle (0 = never).
  task automatic run_pass(input int x0, input int y0, input logic sel,
                          input logic st, input logic cl, input bit poke,
                          input bit chg, input int rst_at);
    int k_done = -1;
    logic eff_clr = cl;
    push_pass(x0, y0, sel, eff_clr, (rst_at > 0) ? rst_at : W * H);
    xorigin  = 8'(x0);
    yorigin  = 7'(y0);
    icon_sel = sel;
    start    = st;
    clear    = cl;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock); #2;
      if (k == 1) begin
        start = 1'b0;
        clear = 1'b0;
        check("busy_first", busy, 1);
      end
      if (rst_at > 0 && k == rst_at + 1) begin
        reset = 1'b0;
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_left", sb.size(), 0);
        break;
      end
      if (rst_at > 0 && k == rst_at) reset = 1'b1;
      if (poke) start = (k == 10);
      if (chg) begin
        xorigin  = 8'($urandom);
        yorigin  = 7'($urandom);
        icon_sel = ~icon_sel;
      end
      if (rst_at == 0 && done) begin
        k_done = k;
        check("busy_at_done", busy, 1);
        check("plots_left", sb.size(), 0);
        break;
      end
    end
    start = 1'b0;
    if (rst_at == 0) begin
      check("done_cycle", k_done, W * H + 1);
      @(posedge clock); #2;
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
    end
    repeat (4) @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; icon_sel = 1'b0;
    xorigin = '0; yorigin = '0;
    repeat (3) @(posedge clock);
    #2;
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clock); #2;

    run_pass(60, 73, 1'b1, 1'b1, 1'b0, 0, 0, 0);   // lock icon
    run_pass(69, 69, 1'b0, 1'b1, 1'b0, 0, 0, 0);   // unlock icon
    run_pass(69, 69, 1'b0, 1'b0, 1'b1, 0, 0, 0);   // clear same footprint
    run_pass(30, 40, 1'b1, 1'b1, 1'b1, 1, 0, 0);   // clear wins, start ignored
    run_pass(10, 20, 1'b1, 1'b1, 1'b0, 0, 0, 20);  // reset mid-pass
    run_pass(11, 22, 1'b0, 1'b1, 1'b0, 0, 0, 0);   // normal after abort
    run_pass(156, 117, 1'b1, 1'b1, 1'b0, 0, 0, 0); // edge of screen
    run_pass(252, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0);   // x wrap
    run_pass(100, 50, 1'b1, 1'b1, 1'b0, 0, 1, 0);  // inputs change mid-pass

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
